sync_fifo_level: RTL and testbench
==================================

Name: sync_fifo_level

Overview:
- Parametrised single-clock FIFO.
- Generalises the team's FIFO pointer/flag scheme in data width, depth and thresholds.
- Adds occupancy level, programmable almost-full/almost-empty flags, registered read-valid and sticky overflow/underflow error flags.
- Used as a buffering stage inside one clock domain, ahead of or behind the async FIFO.

Parameters:
- DATA_WIDTH, 32, width of the data path in bits.
- SIZE_LOG2, 5, log2 of depth; DEPTH = 2**SIZE_LOG2.
- AF_THRESH, DEPTH-2, p_almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1, p_almost_empty asserts when level <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- p_write_en  in  1  write request.
- p_write_data  in  DATA_WIDTH  write data.
- p_write_full  out  1  FIFO full.
- p_read_en  in  1  read request.
- p_read_data  out  DATA_WIDTH  read data, valid when p_read_valid=1.
- p_read_valid  out  1  p_read_data holds the word from the previous accepted read.
- p_read_empty  out  1  FIFO empty.
- p_level  out  SIZE_LOG2+1  current occupancy, 0..DEPTH.
- p_almost_full  out  1  level >= AF_THRESH.
- p_almost_empty  out  1  level <= AE_THRESH.
- p_overflow  out  1  sticky: write attempted while full.
- p_underflow  out  1  sticky: read attempted while empty.
- p_err_clr  in  1  synchronous clear of both sticky error flags.
- p_peak_level  out  SIZE_LOG2+1  high-watermark (see Optional Feature).

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high. The ports are clk and rst.
- Reset values:
  - pointers 0, p_level 0
  - p_read_empty 1, p_write_full 0
  - p_almost_empty 1, p_almost_full 0
  - p_read_valid 0, p_read_data 0
  - p_overflow 0, p_underflow 0, p_peak_level 0
- Reset mid-operation discards all contents immediately; storage array is not cleared.
- Acceptance:
  - Write accepted = p_write_en & ~p_write_full.
  - Read accepted = p_read_en & ~p_read_empty.
  - Flags are the registered values at the clock edge, so full and empty are never bypassed in the same cycle.
- Pointers are SIZE_LOG2+1-bit binary and wrap modulo 2**(SIZE_LOG2+1). Each advances by exactly 1 per accepted operation.
- Full when pointer MSBs differ and lower bits are equal. Empty when the pointers are equal.
- Level = write_ptr - read_ptr, modulo 2**(SIZE_LOG2+1).
- All status outputs are registered and computed from next-state pointers:
  - p_write_full, p_read_empty, p_level, p_almost_full and p_almost_empty all update in the cycle after the accepted operation.
  - They are mutually consistent every cycle.
- Simultaneous operations:
  - Read and write both accepted: level unchanged, flags unchanged.
  - When full, write_en & read_en: read accepted, write rejected and p_overflow set. Level becomes DEPTH-1.
  - When empty, write_en & read_en: write accepted, read rejected and p_underflow set. Level becomes 1.
- Read latency is 1 cycle: an accepted read at edge N produces p_read_data and p_read_valid=1 after edge N+1. p_read_valid=0 in any cycle with no accepted read; p_read_data holds its last value.
- Error flags:
  - p_overflow/p_underflow are set on a rejected request and held until p_err_clr or rst.
  - A set and p_err_clr in the same cycle: set wins.
- Illegal AF_THRESH/AE_THRESH values raise an elaboration-time $error.

Optional Feature:
- Macro: SYNC_FIFO_WATERMARK_EN.
- Defined: p_peak_level tracks the maximum next-level value since reset or the last p_err_clr. It updates in the same cycle as p_level. On p_err_clr it loads the current next level.
- Undefined: no watermark register; p_peak_level is tied to 0. The port list is unchanged.

Decomposition:
- Package sync_fifo_pkg:
  - level-width helper function (SIZE_LOG2+1)
  - threshold-legality check function
  - default-threshold constants
- One sub-module: sync_fifo_ram, a DEPTH x DATA_WIDTH simple dual-port register array with registered read output. The top instantiates the RAM and holds pointers, flags, level and errors.

Test Plan (DATA_WIDTH=8, SIZE_LOG2=3, AF_THRESH=6, AE_THRESH=1):
- Reset → after rst release:
  - empty=1, full=0, level=0, almost_empty=1
  - almost_full=0, read_valid=0, overflow=0, underflow=0
- Write 0x01..0x08 on consecutive cycles:
  - almost_empty drops after 2nd write.
  - almost_full rises after 6th write.
  - full=1 and level=8 after 8th write.
  - Then read 8 times: data 0x01..0x08 in order, each with read_valid 1 cycle after acceptance. Empty=1 after last read.
- Full FIFO, write_en=1 for 1 cycle → pointers unchanged, level=8, p_overflow=1 and held. p_err_clr pulse → p_overflow=0.
- Empty FIFO, write_en & read_en together → level=1, p_underflow=1, read_valid=0 next cycle.
- Level=4, write_en & read_en for 20 cycles (pointer wrap) → level stays 4, flags stable, data order preserved.
- With SYNC_FIFO_WATERMARK_EN: fill to 7, drain to 2 → p_peak_level=7. p_err_clr → p_peak_level=2.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the parametrised single-clock FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SIZE_LOG2  = 5;
    localparam int DEF_AF_MARGIN  = 2;   // default almost-full sits this far below DEPTH
    localparam int DEF_AE_THRESH  = 1;

    function automatic int level_width(input int size_log2);
        return size_log2 + 1;
    endfunction

    function automatic bit thresh_legal(input int size_log2, input int af, input int ae);
        int depth;
        depth = 1 << size_log2;
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_WIDTH simple dual-port register array with a registered read port.
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_LOG2  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [SIZE_LOG2-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [SIZE_LOG2-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**SIZE_LOG2];

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo_level.sv
// Single-clock FIFO with occupancy level, almost-full/empty and sticky error flags.
// Optional high-watermark register enabled by defining SYNC_FIFO_WATERMARK_EN.
module sync_fifo_level
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SIZE_LOG2  = DEF_SIZE_LOG2,
    parameter int AF_THRESH  = (1 << SIZE_LOG2) - DEF_AF_MARGIN,
    parameter int AE_THRESH  = DEF_AE_THRESH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_write_en,
    input  logic [DATA_WIDTH-1:0] p_write_data,
    output logic                  p_write_full,
    input  logic                  p_read_en,
    output logic [DATA_WIDTH-1:0] p_read_data,
    output logic                  p_read_valid,
    output logic                  p_read_empty,
    output logic [SIZE_LOG2:0]    p_level,
    output logic                  p_almost_full,
    output logic                  p_almost_empty,
    output logic                  p_overflow,
    output logic                  p_underflow,
    input  logic                  p_err_clr,
    output logic [SIZE_LOG2:0]    p_peak_level
);

    localparam int LW = level_width(SIZE_LOG2);
    localparam logic [LW-1:0] PTR_ONE = LW'(1);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    if (!thresh_legal(SIZE_LOG2, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
        $error("sync_fifo_level: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
    end

    logic [LW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic          wr_acc, rd_acc, full_nxt, empty_nxt, ov_nxt, uf_nxt;

    // Acceptance uses the registered flags, so full/empty are never bypassed.
    assign wr_acc     = p_write_en & ~p_write_full;
    assign rd_acc     = p_read_en & ~p_read_empty;
    assign wr_ptr_nxt = wr_acc ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = rd_acc ? rd_ptr + PTR_ONE : rd_ptr;
    assign level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    assign full_nxt   = (wr_ptr_nxt[LW-1] != rd_ptr_nxt[LW-1]) &&
                        (wr_ptr_nxt[LW-2:0] == rd_ptr_nxt[LW-2:0]);
    assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    assign ov_nxt     = (p_write_en & p_write_full) | (p_overflow & ~p_err_clr);
    assign uf_nxt     = (p_read_en & p_read_empty) | (p_underflow & ~p_err_clr);

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIZE_LOG2  (SIZE_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[SIZE_LOG2-1:0]),
        .wr_data (p_write_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr[SIZE_LOG2-1:0]),
        .rd_data (p_read_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            p_level        <= '0;
            p_write_full   <= 1'b0;
            p_read_empty   <= 1'b1;
            p_almost_full  <= 1'b0;
            p_almost_empty <= 1'b1;
            p_read_valid   <= 1'b0;
            p_overflow     <= 1'b0;
            p_underflow    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            p_level        <= level_nxt;
            p_write_full   <= full_nxt;
            p_read_empty   <= empty_nxt;
            p_almost_full  <= (level_nxt >= AF_L);
            p_almost_empty <= (level_nxt <= AE_L);
            p_read_valid   <= rd_acc;
            p_overflow     <= ov_nxt;
            p_underflow    <= uf_nxt;
        end
    end

`ifdef SYNC_FIFO_WATERMARK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           p_peak_level <= '0;
        else if (p_err_clr)                p_peak_level <= level_nxt;
        else if (level_nxt > p_peak_level) p_peak_level <= level_nxt;
    end
`else
    assign p_peak_level = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_level.sv
// Self-checking bench for sync_fifo_level: queue-based reference model plus directed literals.
module tb_sync_fifo_level;

    localparam int DW = 8, SL = 3, DEPTH = 8, AF = 6, AE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_write_en, p_read_en, p_err_clr;
    logic [DW-1:0] p_write_data, p_read_data;
    logic          p_write_full, p_read_valid, p_read_empty;
    logic          p_almost_full, p_almost_empty, p_overflow, p_underflow;
    logic [SL:0]   p_level, p_peak_level;

    always #5 clk = ~clk;

    sync_fifo_level #(.DATA_WIDTH(DW), .SIZE_LOG2(SL), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .rst(rst),
        .p_write_en(p_write_en), .p_write_data(p_write_data), .p_write_full(p_write_full),
        .p_read_en(p_read_en), .p_read_data(p_read_data), .p_read_valid(p_read_valid),
        .p_read_empty(p_read_empty), .p_level(p_level),
        .p_almost_full(p_almost_full), .p_almost_empty(p_almost_empty),
        .p_overflow(p_overflow), .p_underflow(p_underflow),
        .p_err_clr(p_err_clr), .p_peak_level(p_peak_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: the FIFO contents as a queue of words.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rdata;
    bit            m_valid, m_ov, m_uf, m_wa, m_ra;
    int            m_peak, m_sz;
    bit            chk_en = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_rdata = '0; m_valid = 0; m_ov = 0; m_uf = 0; m_peak = 0;
        end else begin
            m_sz    = mq.size();
            m_wa    = p_write_en && (m_sz < DEPTH);
            m_ra    = p_read_en && (m_sz > 0);
            m_valid = m_ra;
            if (m_ra) m_rdata = mq.pop_front();
            if (m_wa) mq.push_back(p_write_data);
            m_ov = (p_write_en && !m_wa) ? 1'b1 : (p_err_clr ? 1'b0 : m_ov);
            m_uf = (p_read_en && !m_ra)  ? 1'b1 : (p_err_clr ? 1'b0 : m_uf);
            if (p_err_clr)             m_peak = mq.size();
            else if (mq.size() > m_peak) m_peak = mq.size();
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("level",        int'(p_level),        mq.size());
            chk("full",         int'(p_write_full),   int'(mq.size() == DEPTH));
            chk("empty",        int'(p_read_empty),   int'(mq.size() == 0));
            chk("almost_full",  int'(p_almost_full),  int'(mq.size() >= AF));
            chk("almost_empty", int'(p_almost_empty), int'(mq.size() <= AE));
            chk("overflow",     int'(p_overflow),     int'(m_ov));
            chk("underflow",    int'(p_underflow),    int'(m_uf));
            chk("read_valid",   int'(p_read_valid),   int'(m_valid));
            chk("read_data",    int'(p_read_data),    int'(m_rdata));
`ifdef SYNC_FIFO_WATERMARK_EN
            chk("peak_level",   int'(p_peak_level),   m_peak);
`else
            chk("peak_level",   int'(p_peak_level),   0);
`endif
        end
    end

    task automatic op(input bit w, input int d, input bit r, input bit c);
        p_write_en   = w;
        p_write_data = d[DW-1:0];
        p_read_en    = r;
        p_err_clr    = c;
        @(posedge clk);
        @(negedge clk);
        p_write_en = 0; p_read_en = 0; p_err_clr = 0;
    endtask

    initial begin
        rst = 1; p_write_en = 0; p_read_en = 0; p_err_clr = 0; p_write_data = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("rst_empty", p_read_empty, 1);   chk("rst_full", p_write_full, 0);
        chk("rst_level", p_level, 0);        chk("rst_ae", p_almost_empty, 1);
        chk("rst_af", p_almost_full, 0);     chk("rst_rv", p_read_valid, 0);
        chk("rst_ov", p_overflow, 0);        chk("rst_uf", p_underflow, 0);
        chk("rst_rdata", p_read_data, 0);    chk("rst_peak", p_peak_level, 0);
        chk_en = 1;

        for (int i = 1; i <= 8; i++) begin
            op(1, i, 0, 0);
            if (i == 1) chk("ae_after_1", p_almost_empty, 1);
            if (i == 2) chk("ae_after_2", p_almost_empty, 0);
            if (i == 5) chk("af_after_5", p_almost_full, 0);
            if (i == 6) chk("af_after_6", p_almost_full, 1);
        end
        chk("full_after_8", p_write_full, 1);
        chk("level_after_8", p_level, 8);
        for (int i = 1; i <= 8; i++) begin
            op(0, 0, 1, 0);
            chk("drain_valid", p_read_valid, 1);
            chk("drain_data", p_read_data, i);
        end
        chk("empty_after_drain", p_read_empty, 1);
        op(0, 0, 0, 0);
        chk("idle_valid", p_read_valid, 0);
        chk("idle_hold", p_read_data, 8);

        for (int i = 1; i <= 8; i++) op(1, 'h10 + i, 0, 0);
        op(1, 'hAA, 0, 0);
        chk("ovf_level", p_level, 8);
        chk("ovf_set", p_overflow, 1);
        op(0, 0, 0, 0);
        chk("ovf_held", p_overflow, 1);
        op(0, 0, 0, 1);
        chk("ovf_clr", p_overflow, 0);
        op(1, 'hBB, 1, 0);
        chk("full_rw_level", p_level, 7);
        chk("full_rw_ovf", p_overflow, 1);
        chk("full_rw_data", p_read_data, 'h11);
        op(0, 0, 0, 1);

        for (int i = 0; i < 7; i++) op(0, 0, 1, 0);
        chk("empty_again", p_read_empty, 1);
        op(1, 'h55, 1, 0);
        chk("empty_rw_level", p_level, 1);
        chk("empty_rw_uf", p_underflow, 1);
        chk("empty_rw_rv", p_read_valid, 0);
        op(0, 0, 1, 1);
        chk("uf_clr", p_underflow, 0);
        chk("uf_rdata", p_read_data, 'h55);

        for (int i = 1; i <= 4; i++) op(1, 'h60 + i, 0, 0);
        for (int i = 0; i < 20; i++) op(1, 'h70 + i, 1, 0);
        chk("wrap_level", p_level, 4);
        chk("wrap_af", p_almost_full, 0);
        chk("wrap_ae", p_almost_empty, 0);
        chk("wrap_last", p_read_data, 'h7F);
        for (int i = 0; i < 4; i++) op(0, 0, 1, 0);

        for (int i = 0; i < 3; i++) op(1, 'hC0 + i, 0, 0);
        #2 rst = 1;
        #1 chk("midrst_level", p_level, 0);
        chk("midrst_empty", p_read_empty, 1);
        @(negedge clk);
        rst = 0;
        op(0, 0, 0, 0);
        chk("postrst_level", p_level, 0);

        for (int i = 0; i < 7; i++) op(1, 'hD0 + i, 0, 0);
        for (int i = 0; i < 5; i++) op(0, 0, 1, 0);
`ifdef SYNC_FIFO_WATERMARK_EN
        chk("peak_7", p_peak_level, 7);
        op(0, 0, 0, 1);
        chk("peak_clr_2", p_peak_level, 2);
`else
        chk("peak_tied", p_peak_level, 0);
        op(0, 0, 0, 1);
`endif

        for (int i = 0; i < 4000; i++)
            op($urandom_range(0, 99) < 55, $urandom_range(0, 255),
               $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);

        for (int i = 0; i < DEPTH; i++) op(0, 0, 1, 0);
        chk("final_empty", p_read_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
